// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I immediate generator for the ID stage.
// Decodes I/S/B/U/J and CSR zimm immediates, sign-extends them to XLEN, and carries a tag through a one-deep output register backed by a skid register.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [2:0] {
        SEL_I = 3'd0,
        SEL_S = 3'd1,
        SEL_B = 3'd2,
        SEL_U = 3'd3,
        SEL_J = 3'd4,
        SEL_Z = 3'd5
    } imm_sel_e;

    logic [31:0]      imm_raw;
    logic             dec_err;
    logic [XLEN-1:0]  dec_imm;

    logic             or_valid_reg, or_valid_next;
    logic [XLEN-1:0]  or_imm_reg,   or_imm_next;
    logic             or_err_reg,   or_err_next;
    logic [TAG_W-1:0] or_tag_reg,   or_tag_next;

    logic             sk_valid_reg, sk_valid_next;
    logic [XLEN-1:0]  sk_imm_reg,   sk_imm_next;
    logic             sk_err_reg,   sk_err_next;
    logic [TAG_W-1:0] sk_tag_reg,   sk_tag_next;

    logic             in_ready_reg;
    logic             accept;
    logic             or_free;

    // Opcode bits never contribute to any immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm_raw = 32'd0;
        dec_err = 1'b0;
        case (imm_sel)
            SEL_I:   imm_raw = {{20{instr[31]}}, instr[31:20]};
            SEL_S:   imm_raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            SEL_B:   imm_raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                instr[11:8], 1'b0};
            SEL_U:   imm_raw = {instr[31:12], 12'd0};
            SEL_J:   imm_raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                instr[30:21], 1'b0};
            SEL_Z:   imm_raw = {27'd0, instr[19:15]};
            default: dec_err = 1'b1;
        endcase
    end

    // Bits above 31 replicate bit 31; zimm and illegal results have it clear already.
    generate
        for (genvar gi = 0; gi < XLEN; gi++) begin : g_sext
            if (gi < 32) begin : g_low
                assign dec_imm[gi] = imm_raw[gi];
            end else begin : g_high
                assign dec_imm[gi] = imm_raw[31];
            end
        end
    endgenerate

    // Ready comes from a flop; only reset masks it so nothing is taken during reset.
    assign in_ready = in_ready_reg & ~rst;
    assign accept   = in_valid & in_ready;
    assign or_free  = ~or_valid_reg | out_ready;

    always_comb begin
        or_valid_next = or_valid_reg;
        or_imm_next   = or_imm_reg;
        or_err_next   = or_err_reg;
        or_tag_next   = or_tag_reg;
        sk_valid_next = sk_valid_reg;
        sk_imm_next   = sk_imm_reg;
        sk_err_next   = sk_err_reg;
        sk_tag_next   = sk_tag_reg;
        if (or_free) begin
            // A held skid entry is always older than anything new, and ready is low while it is held.
            if (sk_valid_reg) begin
                or_valid_next = 1'b1;
                or_imm_next   = sk_imm_reg;
                or_err_next   = sk_err_reg;
                or_tag_next   = sk_tag_reg;
                sk_valid_next = 1'b0;
            end else if (accept) begin
                or_valid_next = 1'b1;
                or_imm_next   = dec_imm;
                or_err_next   = dec_err;
                or_tag_next   = in_tag;
            end else begin
                or_valid_next = 1'b0;
            end
        end else if (accept) begin
            sk_valid_next = 1'b1;
            sk_imm_next   = dec_imm;
            sk_err_next   = dec_err;
            sk_tag_next   = in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            or_valid_reg <= 1'b0;
            or_imm_reg   <= '0;
            or_err_reg   <= 1'b0;
            or_tag_reg   <= '0;
            sk_valid_reg <= 1'b0;
            sk_imm_reg   <= '0;
            sk_err_reg   <= 1'b0;
            sk_tag_reg   <= '0;
            in_ready_reg <= 1'b1;
        end else begin
            or_valid_reg <= or_valid_next;
            or_imm_reg   <= or_imm_next;
            or_err_reg   <= or_err_next;
            or_tag_reg   <= or_tag_next;
            sk_valid_reg <= sk_valid_next;
            sk_imm_reg   <= sk_imm_next;
            sk_err_reg   <= sk_err_next;
            sk_tag_reg   <= sk_tag_next;
            in_ready_reg <= ~sk_valid_next;
        end
    end

    assign out_valid = or_valid_reg;
    assign out_imm   = or_imm_reg;
    assign out_err   = or_err_reg;
    assign out_tag   = or_tag_reg;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one input stream;
// expectations come from spec constants or an arithmetic reference model.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready, in_ready64;
    logic [31:0] instr;
    logic [2:0]  imm_sel;
    logic [7:0]  in_tag;
    logic        out_ready;
    logic        out_valid, out_valid64;
    logic [31:0] out_imm;
    logic [63:0] out_imm64;
    logic        out_err, out_err64;
    logic [7:0]  out_tag, out_tag64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .imm_sel(imm_sel), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_err(out_err), .out_tag(out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .imm_sel(imm_sel), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_err(out_err64), .out_tag(out_tag64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm;
        logic        err;
        logic [7:0]  tag;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   checks = 0;
    int   errors = 0;
    bit   rnd_ready = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Immediate computed from field positions with plain arithmetic; returns {err, imm64}.
    function automatic logic [64:0] ref_model(input logic [31:0] ins, input logic [2:0] sel);
        longint w, u, r;
        w = longint'(signed'(ins));
        u = longint'({32'd0, ins});
        case (sel)
            3'd0: r = w >>> 20;
            3'd1: r = (w >>> 25) * 32 + ((u >> 7) & 31);
            3'd2: r = (w >>> 31) * 4096 + ((u >> 7) & 1) * 2048 +
                      ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2;
            3'd3: r = (w >>> 12) * 4096;
            3'd4: r = (w >>> 31) * 1048576 + ((u >> 12) & 255) * 4096 +
                      ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2;
            3'd5: r = (u >> 15) & 31;
            default: return {1'b1, 64'd0};
        endcase
        return {1'b0, r};
    endfunction

    // Called just after a rising edge; holds the input until taken or max_wait cycles pass.
    task automatic send(input logic [31:0] ins, input logic [2:0] sel, input logic [7:0] tag,
                        input logic [63:0] eimm, input logic eerr, input int max_wait,
                        output bit ok);
        exp_t e;
        in_valid = 1'b1;
        instr    = ins;
        imm_sel  = sel;
        in_tag   = tag;
        ok       = 1'b0;
        for (int i = 0; i < max_wait && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.imm = eimm;
                e.err = eerr;
                e.tag = tag;
                q32.push_back(e);
                q64.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        imm_sel  = 3'bx;
    endtask

    // Monitor: pops on every output handshake and checks stability while stalled.
    initial begin
        exp_t        e;
        bit          stall_prev = 0;
        logic [31:0] s_imm;
        logic        s_err;
        logic [7:0]  s_tag;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    chk("stall_imm", {32'd0, out_imm}, {32'd0, s_imm});
                    chk("stall_err", {63'd0, out_err}, {63'd0, s_err});
                    chk("stall_tag", {56'd0, out_tag}, {56'd0, s_tag});
                end
                if (out_valid && out_ready) begin
                    if (q32.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out32: got imm %h tag %h, expected no output",
                                 out_imm, out_tag);
                    end else begin
                        e = q32.pop_front();
                        $display("out32 tag=%h imm=%h err=%0d", out_tag, out_imm, out_err);
                        chk("imm32", {32'd0, out_imm}, {32'd0, e.imm[31:0]});
                        chk("err32", {63'd0, out_err}, {63'd0, e.err});
                        chk("tag32", {56'd0, out_tag}, {56'd0, e.tag});
                    end
                end
                if (out_valid64 && out_ready) begin
                    if (q64.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out64: got imm %h tag %h, expected no output",
                                 out_imm64, out_tag64);
                    end else begin
                        e = q64.pop_front();
                        chk("imm64", out_imm64, e.imm);
                        chk("err64", {63'd0, out_err64}, {63'd0, e.err});
                        chk("tag64", {56'd0, out_tag64}, {56'd0, e.tag});
                    end
                end
                stall_prev = out_valid && !out_ready;
                s_imm = out_imm;
                s_err = out_err;
                s_tag = out_tag;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        bit          ok;
        logic [64:0] m;
        logic [31:0] ri;
        logic [2:0]  rs;
        int          wait_cnt;

        rst       = 1'b1;
        in_valid  = 1'b0;
        instr     = 32'd0;
        imm_sel   = 3'd0;
        in_tag    = 8'd0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_imm", {32'd0, out_imm}, 64'd0);
        chk("rst_out_err", {63'd0, out_err}, 64'd0);
        chk("rst_out_tag", {56'd0, out_tag}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid64", {63'd0, out_valid64}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("post_rst_in_ready64", {63'd0, in_ready64}, 64'd1);
        @(posedge clk);
        #1;

        // I-type with one-cycle latency
        out_ready = 1'b1;
        send(32'hFFF00093, 3'd0, 8'h11, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1, ok);
        chk("t1_accept", {63'd0, ok}, 64'd1);
        @(negedge clk);
        chk("t1_latency", {63'd0, out_valid}, 64'd1);
        @(posedge clk);
        #1;

        // S/B/U/J back-to-back
        send(32'hFE20AE23, 3'd1, 8'h21, 64'hFFFFFFFF_FFFFFFFC, 1'b0, 1, ok);
        chk("t2_s_accept", {63'd0, ok}, 64'd1);
        send(32'hFE000CE3, 3'd2, 8'h22, 64'hFFFFFFFF_FFFFFFF8, 1'b0, 1, ok);
        chk("t2_b_accept", {63'd0, ok}, 64'd1);
        send(32'h123450B7, 3'd3, 8'h23, 64'h00000000_12345000, 1'b0, 1, ok);
        chk("t2_u_accept", {63'd0, ok}, 64'd1);
        send(32'hFFDFF0EF, 3'd4, 8'h24, 64'hFFFFFFFF_FFFFFFFC, 1'b0, 1, ok);
        chk("t2_j_accept", {63'd0, ok}, 64'd1);

        // Illegal select and zimm
        send(32'hFFFFFFFF, 3'd6, 8'h41, 64'd0, 1'b1, 1, ok);
        send(32'hFFFFFFFF, 3'd7, 8'h42, 64'd0, 1'b1, 1, ok);
        send(32'h000F8000, 3'd5, 8'h43, 64'h1F, 1'b0, 1, ok);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: two taken, third refused
        out_ready = 1'b0;
        send(32'h00100093, 3'd0, 8'h31, 64'h1, 1'b0, 1, ok);
        chk("t3_a_accept", {63'd0, ok}, 64'd1);
        send(32'h80000037, 3'd3, 8'h32, 64'hFFFFFFFF_80000000, 1'b0, 1, ok);
        chk("t3_b_accept", {63'd0, ok}, 64'd1);
        in_valid = 1'b1;
        instr    = 32'h7FF00093;
        imm_sel  = 3'd0;
        in_tag   = 8'h33;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_in_ready_low", {63'd0, in_ready}, 64'd0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t3_in_ready_high", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t3_drained", q32.size(), 64'd0);
        @(posedge clk);
        #1;

        // Reset with both registers full
        out_ready = 1'b0;
        send(32'hABCDE0B7, 3'd3, 8'h51, 64'hFFFFFFFF_ABCDE000, 1'b0, 1, ok);
        send(32'h00500093, 3'd0, 8'h52, 64'h5, 1'b0, 1, ok);
        @(negedge clk);
        chk("t6_full_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        q32.delete();
        q64.delete();
        @(negedge clk);
        chk("t6_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t6_out_valid64", {63'd0, out_valid64}, 64'd0);
        chk("t6_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Randomized traffic with random backpressure
        rnd_ready = 1;
        for (int n = 0; n < 300; n++) begin
            ri = $urandom;
            rs = 3'($urandom_range(0, 7));
            m  = ref_model(ri, rs);
            send(ri, rs, 8'($urandom), m[63:0], m[64], 100, ok);
            chk("rand_accept", {63'd0, ok}, 64'd1);
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rnd_ready = 0;
        out_ready = 1'b1;
        wait_cnt  = 0;
        while ((q32.size() != 0 || q64.size() != 0) && wait_cnt < 50) begin
            @(posedge clk);
            wait_cnt++;
        end
        #1;
        chk("final_q32_empty", q32.size(), 64'd0);
        chk("final_q64_empty", q64.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
